// File: rtl/uart_rx.sv
// UART receiver: 2-flop input synchronizer, mid-bit sampling, LSB-first data,
// registered rx_valid / frame_error pulses and break (held-low) handling.
module uart_rx #(
  parameter int unsigned BAUD_RATE = 115200,
  parameter int unsigned CLK_FREQ  = 50_000_000,
  parameter int unsigned DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 serial_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 rx_valid,
  output logic                 frame_error,
  output logic                 rx_busy
);

  localparam int unsigned DIV_RAW  = CLK_FREQ / BAUD_RATE;
  localparam int unsigned DIV      = (DIV_RAW == 0) ? 1 : DIV_RAW;
  localparam int unsigned HALF_RAW = DIV / 2;
  localparam int unsigned HALF     = (HALF_RAW == 0) ? 1 : HALF_RAW;
  localparam int unsigned CW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned IW       = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_t;

  state_t                 state_q, state_d;
  logic                   sync1_q, rx_s_q;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   ferr_q, ferr_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sync1_q <= serial_in;
      rx_s_q  <= sync1_q;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rx_s_q) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        // Re-check the line at mid start bit; a short glitch falls back to IDLE.
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rx_s_q ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
          idx_d   = idx_q + IW'(1);
          if (idx_q == IDX_LAST) begin
            state_d = STOP;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STOP: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d = '0;
          if (rx_s_q) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = WAIT_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      WAIT_IDLE: begin
        if (rx_s_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign data_out    = data_q;
  assign rx_valid    = valid_q;
  assign frame_error = ferr_q;
  assign rx_busy     = (state_q != IDLE);

endmodule
